apb_arb_regs: RTL and testbench

//  APB slave register block upstream of the 4-way arbiter. Holds the bypass, software-request
//  and arbitration-type configuration. Muxes external vs software requests onto the arbiter REQ
//  bus. Samples the arbiter GNT for status, grant counting and a sticky multi-hot error flag.

---
 rtl/apb_arb_regs_if.sv | 20 ++
 rtl/apb_arb_regs.sv | 122 ++++++++++++
 tb/tb_apb_arb_regs.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_regs_if.sv
// APB bus bundle between a master and the arbiter configuration register block.
interface apb_arb_regs_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_arb_regs.sv
// APB register block in front of the 4-way arbiter: bypass/software request muxing,
// arbitration type configuration, grant status, grant event counter and multi-hot error flag.
module apb_arb_regs #(
  parameter int WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  apb_arb_regs_if.slave        apb,
  input  logic [3:0]           EXT_REQ,
  input  logic [3:0]           GNT,
  output logic                 APB_BYPASS,
  output logic [3:0]           APB_REQ,
  output logic [2:0]           APB_ARB_TYPE,
  output logic [3:0]           REQ
);

  localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       w_pready;
  logic       w_xfer;
  logic       w_wr;
  logic       w_event;
  logic       w_multi;
  logic       w_unused;
  logic [7:0] w_rdata;

  logic       r_bypass;
  logic [2:0] r_arb_type;
  logic [3:0] r_req;
  logic [3:0] r_gnt_q;
  logic [7:0] r_gntcnt;
  logic       r_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = LP_WAIT;
        end
      end
      ST_ACCESS: begin
        w_pready = (r_cnt == 3'd0);
        if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
        // A dropped PSEL abandons the access without touching any register.
        if (!apb.PSEL) w_state_nxt = ST_IDLE;
        else if (apb.PENABLE && w_pready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_xfer   = (r_state == ST_ACCESS) && apb.PSEL && apb.PENABLE && w_pready;
  assign w_wr     = w_xfer && apb.PWRITE;
  assign w_event  = (GNT != 4'd0) && (GNT != r_gnt_q);
  assign w_multi  = ((GNT & (GNT - 4'd1)) != 4'd0);
  assign w_unused = apb.PWDATA[7];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_bypass   <= 1'b0;
      r_arb_type <= 3'd0;
      r_req      <= 4'd0;
      r_gnt_q    <= 4'd0;
      r_gntcnt   <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_gnt_q <= GNT;
      if (w_wr && apb.PADDR == 8'h00) begin
        r_bypass   <= apb.PWDATA[0];
        r_arb_type <= apb.PWDATA[6:4];
      end
      if (w_wr && apb.PADDR == 8'h04) r_req <= apb.PWDATA[3:0];
      // Clear beats a coincident grant event.
      if (w_wr && apb.PADDR == 8'h0C) r_gntcnt <= 8'd0;
      else if (w_event && r_gntcnt != 8'hFF) r_gntcnt <= r_gntcnt + 8'd1;
      // Set beats a coincident W1C.
      if (w_multi) r_err <= 1'b1;
      else if (w_wr && apb.PADDR == 8'h10 && apb.PWDATA[0]) r_err <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (apb.PADDR)
      8'h00:   w_rdata = {1'b0, r_arb_type, 3'b000, r_bypass};
      8'h04:   w_rdata = {4'h0, r_req};
      8'h08:   w_rdata = {REQ, GNT};
      8'h0C:   w_rdata = r_gntcnt;
      8'h10:   w_rdata = {7'd0, r_err};
      default: w_rdata = 8'h00;
    endcase
  end

  assign apb.PRDATA   = (w_xfer && !apb.PWRITE) ? w_rdata : 8'h00;
  assign apb.PREADY   = w_pready;
  assign APB_BYPASS   = r_bypass;
  assign APB_REQ      = r_req;
  assign APB_ARB_TYPE = r_arb_type;
  assign REQ          = r_bypass ? r_req : EXT_REQ;

endmodule

// File: tb/tb_apb_arb_regs.sv
// Directed bench for apb_arb_regs: a zero-wait instance plus a 2-wait-state instance.
module tb_apb_arb_regs;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic [3:0] EXT_REQ = 4'hA;
  logic [3:0] GNT = 4'h0;

  logic       byp0, byp2;
  logic [3:0] apbreq0, apbreq2, req0, req2;
  logic [2:0] arb0, arb2;

  int pass_cnt = 0;
  int total_cnt = 0;

  apb_arb_regs_if bus0();
  apb_arb_regs_if bus2();

  apb_arb_regs #(.WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0), .EXT_REQ(EXT_REQ), .GNT(GNT),
    .APB_BYPASS(byp0), .APB_REQ(apbreq0), .APB_ARB_TYPE(arb0), .REQ(req0)
  );

  apb_arb_regs #(.WAIT_STATES(2)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus2), .EXT_REQ(EXT_REQ), .GNT(GNT),
    .APB_BYPASS(byp2), .APB_REQ(apbreq2), .APB_ARB_TYPE(arb2), .REQ(req2)
  );

  always #5 PCLK = ~PCLK;

  task automatic drive(input bit s2, input logic psel, input logic pen, input logic pwr,
                       input logic [7:0] addr, input logic [7:0] data);
    if (s2) begin
      bus2.PSEL = psel; bus2.PENABLE = pen; bus2.PWRITE = pwr;
      bus2.PADDR = addr; bus2.PWDATA = data;
    end else begin
      bus0.PSEL = psel; bus0.PENABLE = pen; bus0.PWRITE = pwr;
      bus0.PADDR = addr; bus0.PWDATA = data;
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that completes the transfer.
  task automatic apb_xfer(input bit s2, input logic pwr, input logic [7:0] addr,
                          input logic [7:0] data, output logic [7:0] rdata, output int waits);
    int budget;
    logic rdy;
    waits = 0;
    budget = 20;
    drive(s2, 1'b1, 1'b0, pwr, addr, data);
    @(posedge PCLK); #1;
    drive(s2, 1'b1, 1'b1, pwr, addr, data);
    @(negedge PCLK);
    rdy = s2 ? bus2.PREADY : bus0.PREADY;
    while (!rdy && budget > 0) begin
      waits++;
      budget--;
      @(posedge PCLK); #1;
      @(negedge PCLK);
      rdy = s2 ? bus2.PREADY : bus0.PREADY;
    end
    if (!rdy) begin
      total_cnt++;
      $display("FAIL apb_timeout: PREADY got 0 after %0d cycles, expected 1 (addr %h)", waits, addr);
    end
    rdata = s2 ? bus2.PRDATA : bus0.PRDATA;
    @(posedge PCLK); #1;
    drive(s2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic apb_wr(input bit s2, input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rd;
    int w;
    apb_xfer(s2, 1'b1, addr, data, rd, w);
  endtask

  task automatic apb_rd(input bit s2, input logic [7:0] addr, output logic [7:0] data);
    int w;
    apb_xfer(s2, 1'b0, addr, 8'h00, data, w);
  endtask

  task automatic test_reset();
    logic [7:0] addrs [4];
    logic [7:0] rd;
    addrs = '{8'h00, 8'h04, 8'h0C, 8'h10};
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    total_cnt++;
    if (bus0.PREADY !== 1'b0) $display("FAIL reset_pready: got %b expected 0", bus0.PREADY);
    else pass_cnt++;
    total_cnt++;
    if (req0 !== 4'hA) $display("FAIL reset_req: got %h expected a", req0);
    else pass_cnt++;
    @(posedge PCLK); #1;
    for (int i = 0; i < 4; i++) begin
      apb_rd(1'b0, addrs[i], rd);
      total_cnt++;
      if (rd !== 8'h00) $display("FAIL reset_read_%h: got %h expected 00", addrs[i], rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_config();
    logic [7:0] rd;
    apb_wr(1'b0, 8'h00, 8'h31);
    apb_wr(1'b0, 8'h04, 8'h05);
    EXT_REQ = 4'h3;
    @(negedge PCLK);
    total_cnt++;
    if (byp0 !== 1'b1) $display("FAIL cfg_bypass: got %b expected 1", byp0);
    else pass_cnt++;
    total_cnt++;
    if (arb0 !== 3'd3) $display("FAIL cfg_arb_type: got %0d expected 3", arb0);
    else pass_cnt++;
    total_cnt++;
    if (req0 !== 4'h5) $display("FAIL cfg_req_mux: got %h expected 5", req0);
    else pass_cnt++;
    total_cnt++;
    if (bus0.PRDATA !== 8'h00) $display("FAIL idle_prdata: got %h expected 00", bus0.PRDATA);
    else pass_cnt++;
    @(posedge PCLK); #1;
    apb_rd(1'b0, 8'h00, rd);
    total_cnt++;
    if (rd !== 8'h31) $display("FAIL cfg_ctrl_read: got %h expected 31", rd);
    else pass_cnt++;
    apb_rd(1'b0, 8'h04, rd);
    total_cnt++;
    if (rd !== 8'h05) $display("FAIL cfg_req_read: got %h expected 05", rd);
    else pass_cnt++;
    apb_rd(1'b0, 8'h01, rd);
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL unmapped_read: got %h expected 00", rd);
    else pass_cnt++;
    apb_rd(1'b0, 8'h08, rd);
    total_cnt++;
    if (rd !== 8'h50) $display("FAIL status_read0: got %h expected 50", rd);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    logic [7:0] rd;
    int w;
    apb_wr(1'b1, 8'h00, 8'h01);
    apb_wr(1'b1, 8'h04, 8'h05);
    GNT = 4'h4;
    EXT_REQ = 4'h9;
    apb_xfer(1'b1, 1'b0, 8'h08, 8'h00, rd, w);
    total_cnt++;
    if (w !== 2) $display("FAIL ws2_wait_cycles: got %0d expected 2", w);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 8'h54) $display("FAIL ws2_status: got %h expected 54", rd);
    else pass_cnt++;
    apb_xfer(1'b0, 1'b0, 8'h08, 8'h00, rd, w);
    total_cnt++;
    if (w !== 0) $display("FAIL ws0_wait_cycles: got %0d expected 0", w);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    apb_wr(1'b0, 8'h04, 8'h0C);
    apb_wr(1'b0, 8'h04, 8'h03);
    total_cnt++;
    if ($time - t0 !== 40) $display("FAIL b2b_duration: got %0t expected 40", $time - t0);
    else pass_cnt++;
    @(negedge PCLK);
    total_cnt++;
    if (apbreq0 !== 4'h3) $display("FAIL b2b_req: got %h expected 3", apbreq0);
    else pass_cnt++;
    @(posedge PCLK); #1;
  endtask

  task automatic test_grant_count();
    logic [7:0] rd;
    logic [3:0] seq [6];
    seq = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h0, 4'h2};
    GNT = 4'h0;
    @(posedge PCLK); #1;
    apb_wr(1'b0, 8'h0C, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      GNT = seq[i];
      @(posedge PCLK); #1;
    end
    apb_rd(1'b0, 8'h0C, rd);
    total_cnt++;
    if (rd !== 8'h03) $display("FAIL gntcnt_seq: got %h expected 03", rd);
    else pass_cnt++;
    for (int i = 0; i < 300; i++) begin
      GNT = (i % 2 == 0) ? 4'h1 : 4'h2;
      @(posedge PCLK); #1;
    end
    apb_rd(1'b0, 8'h0C, rd);
    total_cnt++;
    if (rd !== 8'hFF) $display("FAIL gntcnt_saturate: got %h expected ff", rd);
    else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h0C, 8'h5A);
    @(posedge PCLK); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h0C, 8'h5A);
    GNT = 4'h1;
    @(posedge PCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_rd(1'b0, 8'h0C, rd);
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL gntcnt_clear_wins: got %h expected 00", rd);
    else pass_cnt++;
  endtask

  task automatic test_err();
    logic [7:0] rd;
    GNT = 4'h0;
    @(posedge PCLK); #1;
    apb_rd(1'b0, 8'h10, rd);
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL err_clean: got %h expected 00", rd);
    else pass_cnt++;
    GNT = 4'h3;
    @(posedge PCLK); #1;
    GNT = 4'h0;
    apb_rd(1'b0, 8'h10, rd);
    total_cnt++;
    if (rd !== 8'h01) $display("FAIL err_set: got %h expected 01", rd);
    else pass_cnt++;
    apb_wr(1'b0, 8'h10, 8'h00);
    apb_rd(1'b0, 8'h10, rd);
    total_cnt++;
    if (rd !== 8'h01) $display("FAIL err_w0_keeps: got %h expected 01", rd);
    else pass_cnt++;
    apb_wr(1'b0, 8'h10, 8'h01);
    apb_rd(1'b0, 8'h10, rd);
    total_cnt++;
    if (rd !== 8'h00) $display("FAIL err_w1c: got %h expected 00", rd);
    else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h01);
    @(posedge PCLK); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h01);
    GNT = 4'h3;
    @(posedge PCLK); #1;
    GNT = 4'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_rd(1'b0, 8'h10, rd);
    total_cnt++;
    if (rd !== 8'h01) $display("FAIL err_set_wins: got %h expected 01", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_transfer();
    apb_wr(1'b0, 8'h00, 8'h00);
    EXT_REQ = 4'h6;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);
    @(posedge PCLK); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h01);
    #2 PRESETn = 1'b0;
    #1;
    total_cnt++;
    if (bus0.PREADY !== 1'b0) $display("FAIL rst_mid_pready: got %b expected 0", bus0.PREADY);
    else pass_cnt++;
    @(posedge PCLK); #1;
    total_cnt++;
    if (byp0 !== 1'b0) $display("FAIL rst_mid_bypass: got %b expected 0", byp0);
    else pass_cnt++;
    PRESETn = 1'b1;
    repeat (2) begin
      @(negedge PCLK);
      total_cnt++;
      if (bus0.PREADY !== 1'b0) $display("FAIL rst_mid_idle: got PREADY %b expected 0", bus0.PREADY);
      else pass_cnt++;
    end
    @(posedge PCLK); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge PCLK);
    total_cnt++;
    if (byp0 !== 1'b0) $display("FAIL rst_mid_no_commit: got %b expected 0", byp0);
    else pass_cnt++;
    total_cnt++;
    if (req0 !== 4'h6) $display("FAIL rst_mid_req: got %h expected 6", req0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_config();
    test_wait_states();
    test_back_to_back();
    test_grant_count();
    test_err();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
